// File: rtl/prim_ram_pkg.sv
// Shared types and helpers for the two-port RAM with a power-on clear sweep.
// Holds the init FSM state encoding and the write-lane count derivation.
package prim_ram_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StSweep = 1'b1
    } init_state_e;

    function automatic int unsigned lane_count(input int unsigned width,
                                               input int unsigned bits_per_mask);
        return width / bits_per_mask;
    endfunction

endpackage

// File: rtl/prim_generic_ram_2p_core.sv
// Storage array: one write/read port (A) and one read-only port (B), no reset.
// Reads are combinational; the top registers them, which gives read-first behaviour.
module prim_generic_ram_2p_core #(
    parameter int Width           = 32,
    parameter int Depth           = 128,
    parameter int DataBitsPerMask = 8,
    parameter int Lanes           = 4,
    parameter int Aw              = 7
) (
    input  logic             clk_i,
    input  logic             a_we_i,
    input  logic [Aw-1:0]    a_addr_i,
    input  logic [Width-1:0] a_wdata_i,
    input  logic [Lanes-1:0] a_lane_we_i,
    output logic [Width-1:0] a_rdata_o,
    input  logic [Aw-1:0]    b_addr_i,
    output logic [Width-1:0] b_rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    // Lane-granular write; untouched lanes keep their contents.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < Lanes; i++) begin
            if (a_we_i && a_lane_we_i[i]) begin
                mem_q[a_addr_i][i*DataBitsPerMask +: DataBitsPerMask] <=
                    a_wdata_i[i*DataBitsPerMask +: DataBitsPerMask];
            end
        end
    end

    assign a_rdata_o = mem_q[a_addr_i];
    assign b_rdata_o = mem_q[b_addr_i];

endmodule

// File: rtl/prim_generic_ram_2p_init.sv
// Two-port RAM with lane-masked writes, optional output stage and a clear sweep
// that runs after reset and on request; requests are dropped while it runs.
module prim_generic_ram_2p_init
    import prim_ram_pkg::*;
#(
    parameter int               Width           = 32,
    parameter int               Depth           = 128,
    parameter int               DataBitsPerMask = 8,
    parameter bit               OutputReg       = 1'b0,
    parameter bit               InitOnReset     = 1'b1,
    parameter logic [Width-1:0] InitValue       = '0,
    localparam int              Aw              = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             a_req_i,
    input  logic             a_write_i,
    input  logic [Aw-1:0]    a_addr_i,
    input  logic [Width-1:0] a_wdata_i,
    input  logic [Width-1:0] a_wmask_i,
    output logic [Width-1:0] a_rdata_o,
    output logic             a_rvalid_o,
    input  logic             b_req_i,
    input  logic [Aw-1:0]    b_addr_i,
    output logic [Width-1:0] b_rdata_o,
    output logic             b_rvalid_o,
    input  logic             init_req_i,
    output logic             init_busy_o,
    input  logic [9:0]       cfg_i
);

    localparam int            Lanes    = lane_count(Width, DataBitsPerMask);
    localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

    init_state_e      state_q, state_d;
    logic [Aw-1:0]    cnt_q, cnt_d;
    logic             sweep_s;
    logic             a_rd_s, b_rd_s;
    logic [Lanes-1:0] a_lane_s;
    logic             mem_we_s;
    logic [Aw-1:0]    mem_addr_s;
    logic [Width-1:0] mem_wdata_s;
    logic [Lanes-1:0] mem_lane_s;
    logic [Width-1:0] core_a_rdata_s, core_b_rdata_s;
    logic             a_rvalid1_q, b_rvalid1_q;
    logic [Width-1:0] a_rdata1_q, b_rdata1_q;
    logic             unused_cfg_s;

    assign unused_cfg_s = ^cfg_i;
    assign sweep_s      = (state_q == StSweep);
    assign init_busy_o  = sweep_s;
    assign a_rd_s       = a_req_i && !a_write_i && !sweep_s;
    assign b_rd_s       = b_req_i && !sweep_s;

    // A lane is written only when every mask bit of that lane is set.
    for (genvar i = 0; i < Lanes; i++) begin : g_lane
        assign a_lane_s[i] = &a_wmask_i[i*DataBitsPerMask +: DataBitsPerMask];
    end

    // Init FSM state and sweep address register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= InitOnReset ? StSweep : StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the terminal compare keeps cnt inside a non-power-of-two Depth.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (init_req_i) begin
                    state_d = StSweep;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StSweep: begin
                if (cnt_q == LastAddr) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + Aw'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Write port arbitration: the sweep owns port A while it runs.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = a_addr_i;
        mem_wdata_s = a_wdata_i;
        mem_lane_s  = a_lane_s;
        if (sweep_s) begin
            mem_we_s    = !rst_i;
            mem_addr_s  = cnt_q;
            mem_wdata_s = InitValue;
            mem_lane_s  = '1;
        end else begin
            mem_we_s = !rst_i && a_req_i && a_write_i;
        end
    end

    prim_generic_ram_2p_core #(
        .Width           (Width),
        .Depth           (Depth),
        .DataBitsPerMask (DataBitsPerMask),
        .Lanes           (Lanes),
        .Aw              (Aw)
    ) u_core (
        .clk_i       (clk_i),
        .a_we_i      (mem_we_s),
        .a_addr_i    (mem_addr_s),
        .a_wdata_i   (mem_wdata_s),
        .a_lane_we_i (mem_lane_s),
        .a_rdata_o   (core_a_rdata_s),
        .b_addr_i    (b_addr_i),
        .b_rdata_o   (core_b_rdata_s)
    );

    // First read stage; data only loads on an accepted read so writes leave it held.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_rvalid1_q <= 1'b0;
            b_rvalid1_q <= 1'b0;
            a_rdata1_q  <= '0;
            b_rdata1_q  <= '0;
        end else begin
            a_rvalid1_q <= a_rd_s;
            b_rvalid1_q <= b_rd_s;
            if (a_rd_s) begin
                a_rdata1_q <= core_a_rdata_s;
            end
            if (b_rd_s) begin
                b_rdata1_q <= core_b_rdata_s;
            end
        end
    end

    if (OutputReg) begin : g_outreg
        logic             a_rvalid2_q, b_rvalid2_q;
        logic [Width-1:0] a_rdata2_q, b_rdata2_q;

        // Optional second stage, loaded only from valid first-stage data.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                a_rvalid2_q <= 1'b0;
                b_rvalid2_q <= 1'b0;
                a_rdata2_q  <= '0;
                b_rdata2_q  <= '0;
            end else begin
                a_rvalid2_q <= a_rvalid1_q;
                b_rvalid2_q <= b_rvalid1_q;
                if (a_rvalid1_q) begin
                    a_rdata2_q <= a_rdata1_q;
                end
                if (b_rvalid1_q) begin
                    b_rdata2_q <= b_rdata1_q;
                end
            end
        end

        assign a_rvalid_o = a_rvalid2_q;
        assign b_rvalid_o = b_rvalid2_q;
        assign a_rdata_o  = a_rdata2_q;
        assign b_rdata_o  = b_rdata2_q;
    end else begin : g_noreg
        assign a_rvalid_o = a_rvalid1_q;
        assign b_rvalid_o = b_rvalid1_q;
        assign a_rdata_o  = a_rdata1_q;
        assign b_rdata_o  = b_rdata1_q;
    end

endmodule

// File: tb/tb_prim_generic_ram_2p_init.sv
// Directed bench: default instance (Depth 128, no output stage) and a second
// instance with Depth 100 and the output stage enabled.
module tb_prim_generic_ram_2p_init;

    logic        clk;
    logic        rst, rst1;
    int          errors;
    int          checks;

    logic        a_req, a_write, b_req, init_req, a_rvalid, b_rvalid, busy;
    logic [6:0]  a_addr, b_addr;
    logic [31:0] a_wdata, a_wmask, a_rdata, b_rdata;
    logic [9:0]  cfg;

    logic        d1_a_req, d1_a_write, d1_b_req, d1_init_req;
    logic        d1_a_rvalid, d1_b_rvalid, d1_busy;
    logic [6:0]  d1_a_addr, d1_b_addr;
    logic [31:0] d1_a_wdata, d1_a_wmask, d1_a_rdata, d1_b_rdata;

    prim_generic_ram_2p_init dut (
        .clk_i(clk), .rst_i(rst),
        .a_req_i(a_req), .a_write_i(a_write), .a_addr_i(a_addr),
        .a_wdata_i(a_wdata), .a_wmask_i(a_wmask),
        .a_rdata_o(a_rdata), .a_rvalid_o(a_rvalid),
        .b_req_i(b_req), .b_addr_i(b_addr),
        .b_rdata_o(b_rdata), .b_rvalid_o(b_rvalid),
        .init_req_i(init_req), .init_busy_o(busy), .cfg_i(cfg)
    );

    prim_generic_ram_2p_init #(.Depth(100), .OutputReg(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst1),
        .a_req_i(d1_a_req), .a_write_i(d1_a_write), .a_addr_i(d1_a_addr),
        .a_wdata_i(d1_a_wdata), .a_wmask_i(d1_a_wmask),
        .a_rdata_o(d1_a_rdata), .a_rvalid_o(d1_a_rvalid),
        .b_req_i(d1_b_req), .b_addr_i(d1_b_addr),
        .b_rdata_o(d1_b_rdata), .b_rvalid_o(d1_b_rvalid),
        .init_req_i(d1_init_req), .init_busy_o(d1_busy), .cfg_i(cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wr0(input logic [6:0] addr, input logic [31:0] data, input logic [31:0] mask);
        a_req = 1'b1; a_write = 1'b1; a_addr = addr; a_wdata = data; a_wmask = mask;
        @(negedge clk);
        a_req = 1'b0; a_write = 1'b0;
    endtask

    task automatic wr1(input logic [6:0] addr, input logic [31:0] data);
        d1_a_req = 1'b1; d1_a_write = 1'b1; d1_a_addr = addr;
        d1_a_wdata = data; d1_a_wmask = 32'hFFFF_FFFF;
        @(negedge clk);
        d1_a_req = 1'b0; d1_a_write = 1'b0;
    endtask

    task automatic rd_a0(input logic [6:0] addr, output logic [31:0] data, output logic vld);
        a_req = 1'b1; a_write = 1'b0; a_addr = addr;
        @(negedge clk);
        a_req = 1'b0;
        data = a_rdata; vld = a_rvalid;
    endtask

    task automatic rd_b0(input logic [6:0] addr, output logic [31:0] data, output logic vld);
        b_req = 1'b1; b_addr = addr;
        @(negedge clk);
        b_req = 1'b0;
        data = b_rdata; vld = b_rvalid;
    endtask

    task automatic test_reset;
        int n0, n1;
        rst = 1'b1; rst1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL reset_a_rdata: got %h expected 00000000", a_rdata); end
        checks++; if (b_rdata !== 32'h0) begin errors++; $display("FAIL reset_b_rdata: got %h expected 00000000", b_rdata); end
        checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b expected 00", a_rvalid, b_rvalid); end
        checks++; if (busy !== 1'b1 || d1_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b%b expected 11", busy, d1_busy); end
        rst = 1'b0; rst1 = 1'b0;
        n0 = 0; n1 = 0;
        for (int k = 0; k < 1000 && (busy === 1'b1 || d1_busy === 1'b1); k++) begin
            if (busy === 1'b1) n0++;
            if (d1_busy === 1'b1) n1++;
            @(negedge clk);
        end
        checks++; if (n0 !== 128) begin errors++; $display("FAIL sweep_len_128: got %0d expected 128", n0); end
        checks++; if (n1 !== 100) begin errors++; $display("FAIL sweep_len_100: got %0d expected 100", n1); end
    endtask

    task automatic test_sweep_clear;
        logic [31:0] d;
        logic        v;
        for (int i = 0; i < 128; i++) begin
            rd_b0(7'(i), d, v);
            checks++;
            if (v !== 1'b1 || d !== 32'h0) begin
                errors++; $display("FAIL sweep_zero[%0d]: got v=%b d=%h expected v=1 d=00000000", i, v, d);
            end
        end
    endtask

    task automatic test_mask;
        logic [31:0] d;
        logic        v;
        wr0(7'h10, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        wr0(7'h10, 32'h1122_3344, 32'h00FF_00FF);
        rd_a0(7'h10, d, v);
        checks++; if (v !== 1'b1 || d !== 32'hDE22_BE44) begin errors++; $display("FAIL mask_read: got v=%b d=%h expected v=1 d=de22be44", v, d); end
        // Partial lanes (0x0F) must not write; write must not pulse rvalid or change rdata.
        a_req = 1'b1; a_write = 1'b1; a_addr = 7'h10; a_wdata = 32'h5555_5555; a_wmask = 32'h0F00_FF0F;
        @(negedge clk);
        a_req = 1'b0; a_write = 1'b0;
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL write_no_rvalid: got %b expected 0", a_rvalid); end
        checks++; if (a_rdata !== 32'hDE22_BE44) begin errors++; $display("FAIL write_hold_rdata: got %h expected de22be44", a_rdata); end
        rd_b0(7'h10, d, v);
        checks++; if (v !== 1'b1 || d !== 32'hDE22_5544) begin errors++; $display("FAIL partial_lane: got v=%b d=%h expected v=1 d=de225544", v, d); end
    endtask

    task automatic test_read_first;
        logic [31:0] d;
        logic        v;
        wr0(7'h05, 32'h0BAD_F00D, 32'hFFFF_FFFF);
        a_req = 1'b1; a_write = 1'b1; a_addr = 7'h05; a_wdata = 32'hA5A5_A5A5; a_wmask = 32'hFFFF_FFFF;
        b_req = 1'b1; b_addr = 7'h05;
        @(negedge clk);
        a_req = 1'b0; a_write = 1'b0; b_req = 1'b0;
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL read_first_old: got v=%b d=%h expected v=1 d=0badf00d", b_rvalid, b_rdata); end
        rd_b0(7'h05, d, v);
        checks++; if (v !== 1'b1 || d !== 32'hA5A5_A5A5) begin errors++; $display("FAIL read_first_new: got v=%b d=%h expected v=1 d=a5a5a5a5", v, d); end
    endtask

    task automatic test_output_reg;
        wr1(7'h01, 32'h1111_1111);
        wr1(7'h02, 32'h2222_2222);
        wr1(7'd99, 32'hCAFE_F00D);
        d1_a_req = 1'b1; d1_a_write = 1'b0; d1_a_addr = 7'h01;
        @(negedge clk);
        d1_a_addr = 7'h02;
        checks++; if (d1_a_rvalid !== 1'b0) begin errors++; $display("FAIL oreg_cycle1: got rvalid %b expected 0", d1_a_rvalid); end
        @(negedge clk);
        d1_a_req = 1'b0;
        checks++; if (d1_a_rvalid !== 1'b1 || d1_a_rdata !== 32'h1111_1111) begin errors++; $display("FAIL oreg_cycle2: got v=%b d=%h expected v=1 d=11111111", d1_a_rvalid, d1_a_rdata); end
        @(negedge clk);
        checks++; if (d1_a_rvalid !== 1'b1 || d1_a_rdata !== 32'h2222_2222) begin errors++; $display("FAIL oreg_cycle3: got v=%b d=%h expected v=1 d=22222222", d1_a_rvalid, d1_a_rdata); end
        @(negedge clk);
        checks++; if (d1_a_rvalid !== 1'b0 || d1_a_rdata !== 32'h2222_2222) begin errors++; $display("FAIL oreg_hold: got v=%b d=%h expected v=0 d=22222222", d1_a_rvalid, d1_a_rdata); end
        d1_b_req = 1'b1; d1_b_addr = 7'd99;
        @(negedge clk);
        d1_b_req = 1'b0;
        checks++; if (d1_b_rvalid !== 1'b0) begin errors++; $display("FAIL oreg_b_cycle1: got rvalid %b expected 0", d1_b_rvalid); end
        @(negedge clk);
        checks++; if (d1_b_rvalid !== 1'b1 || d1_b_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL oreg_b_last_addr: got v=%b d=%h expected v=1 d=cafef00d", d1_b_rvalid, d1_b_rdata); end
    endtask

    task automatic test_sweep_reset;
        int          n;
        logic [31:0] d;
        logic        v;
        // Read accepted in the same cycle the sweep starts completes with old data.
        b_req = 1'b1; b_addr = 7'h05; init_req = 1'b1;
        @(negedge clk);
        b_req = 1'b0; init_req = 1'b0;
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL inflight_read: got v=%b d=%h expected v=1 d=a5a5a5a5", b_rvalid, b_rdata); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL init_req_start: got busy %b expected 1", busy); end
        for (int k = 0; k < 39; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a_req = 1'b1; a_write = 1'b0; a_addr = 7'h05; b_req = 1'b1; b_addr = 7'h10;
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            init_req = (k == 5);
            checks++;
            if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
                errors++; $display("FAIL sweep_drop[%0d]: got rvalid %b%b expected 00", k, a_rvalid, b_rvalid);
            end
            if (busy !== 1'b1) break;
            n++;
            @(negedge clk);
        end
        a_req = 1'b0; b_req = 1'b0; init_req = 1'b0;
        checks++; if (n !== 128) begin errors++; $display("FAIL restart_len: got %0d expected 128", n); end
        rd_a0(7'h05, d, v);
        checks++; if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL restart_clear_05: got v=%b d=%h expected v=1 d=00000000", v, d); end
        rd_b0(7'h10, d, v);
        checks++; if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL restart_clear_10: got v=%b d=%h expected v=1 d=00000000", v, d); end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; rst1 = 1'b1; cfg = 10'h0;
        a_req = 1'b0; a_write = 1'b0; a_addr = 7'h0; a_wdata = 32'h0; a_wmask = 32'h0;
        b_req = 1'b0; b_addr = 7'h0; init_req = 1'b0;
        d1_a_req = 1'b0; d1_a_write = 1'b0; d1_a_addr = 7'h0; d1_a_wdata = 32'h0; d1_a_wmask = 32'h0;
        d1_b_req = 1'b0; d1_b_addr = 7'h0; d1_init_req = 1'b0;
        test_reset;
        test_sweep_clear;
        test_mask;
        test_read_first;
        test_output_reg;
        test_sweep_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
